// File: rtl/controlador_entrada.sv
// Button input conditioning: 2-FF synchroniser, debounce and classification of
// each press into single-cycle short, long and two-button combo events.
module controlador_entrada #(
  parameter int DEBOUNCE_CYCLES = 270000,
  parameter int LONG_CYCLES     = 27000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic b1,
  input  logic b2,
  output logic b1_nivel,
  output logic b2_nivel,
  output logic b1_curto,
  output logic b2_curto,
  output logic b1_longo,
  output logic b2_longo,
  output logic ambos
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HW = $clog2(LONG_CYCLES);
  localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_CYCLES - 1);

  typedef enum logic [1:0] {
    SOLTO,
    PRESSIONADO,
    LONGO,
    INIBIDO
  } estado_t;

  logic [1:0] w_pin;
  logic [1:0] w_nivel;
  logic [1:0] w_livre;
  logic [1:0] w_curto;
  logic [1:0] w_longo;
  logic       w_combo;
  logic       w_soltos;
  logic       r_ambos;

  assign w_pin    = {b2, b1};
  // A combo needs both buttons down while neither is already committed to
  // a long hold or an earlier combo.
  assign w_combo  = (&w_nivel) & (&w_livre);
  assign w_soltos = ~(|w_nivel);

  for (genvar gi = 0; gi < 2; gi++) begin : g_botao
    logic          r_sync1;
    logic          r_sync2;
    logic          r_nivel;
    logic [DW-1:0] r_deb_cnt;
    estado_t       r_estado;
    estado_t       w_estado_next;
    logic [HW-1:0] r_hold;
    logic [HW-1:0] w_hold_next;
    logic          r_curto;
    logic          r_longo;
    logic          w_curto_next;
    logic          w_longo_next;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_sync1 <= 1'b0;
        r_sync2 <= 1'b0;
      end else begin
        r_sync1 <= ~w_pin[gi];
        r_sync2 <= r_sync1;
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_nivel   <= 1'b0;
        r_deb_cnt <= '0;
      end else if (r_sync2 == r_nivel) begin
        r_deb_cnt <= '0;
      end else if (r_deb_cnt == DEB_LAST) begin
        r_nivel   <= ~r_nivel;
        r_deb_cnt <= '0;
      end else begin
        r_deb_cnt <= r_deb_cnt + DW'(1);
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_estado <= SOLTO;
        r_hold   <= '0;
        r_curto  <= 1'b0;
        r_longo  <= 1'b0;
      end else begin
        r_estado <= w_estado_next;
        r_hold   <= w_hold_next;
        r_curto  <= w_curto_next;
        r_longo  <= w_longo_next;
      end
    end

    always_comb begin
      w_estado_next = r_estado;
      w_hold_next   = r_hold;
      w_curto_next  = 1'b0;
      w_longo_next  = 1'b0;
      if (w_combo) begin
        // Combo takes precedence over a long threshold reached this cycle.
        w_estado_next = INIBIDO;
      end else begin
        case (r_estado)
          SOLTO: begin
            if (r_nivel) begin
              w_estado_next = PRESSIONADO;
              w_hold_next   = '0;
            end
          end
          PRESSIONADO: begin
            if (!r_nivel) begin
              w_curto_next  = 1'b1;
              w_estado_next = SOLTO;
            end else if (r_hold == HOLD_LAST) begin
              w_longo_next  = 1'b1;
              w_estado_next = LONGO;
            end else begin
              w_hold_next = r_hold + HW'(1);
            end
          end
          LONGO: begin
            if (!r_nivel) w_estado_next = SOLTO;
          end
          INIBIDO: begin
            // Stay silent until both buttons are up, so neither can report
            // a press that started as part of the combo.
            if (w_soltos) w_estado_next = SOLTO;
          end
          default: w_estado_next = SOLTO;
        endcase
      end
    end

    assign w_nivel[gi] = r_nivel;
    assign w_livre[gi] = (r_estado == SOLTO) || (r_estado == PRESSIONADO);
    assign w_curto[gi] = r_curto;
    assign w_longo[gi] = r_longo;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_ambos <= 1'b0;
    else        r_ambos <= w_combo;
  end

  assign b1_nivel = w_nivel[0];
  assign b2_nivel = w_nivel[1];
  assign b1_curto = w_curto[0];
  assign b2_curto = w_curto[1];
  assign b1_longo = w_longo[0];
  assign b2_longo = w_longo[1];
  assign ambos    = r_ambos;

endmodule
